// File: rtl/vref_profile_gen.sv
// Programmable multi-level reference generator for the 3LFCC control loop.
// Steps through a level table per mode, with optional per-cycle slew limiting of vref_o.
module vref_profile_gen #(
  parameter int DATA_W      = 16,
  parameter int NUM_LEVELS  = 4,
  parameter int STEP_CYCLES = 1000000,
  parameter int IDX_W       = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
  parameter int CNT_W       = $clog2(STEP_CYCLES)
) (
  input  logic                           clk_100m,
  input  logic                           rst_ni,
  input  logic                           en_i,
  input  logic [1:0]                     mode_i,
  input  logic [IDX_W-1:0]               sel_i,
  input  logic [NUM_LEVELS*DATA_W-1:0]   levels_i,
  input  logic [DATA_W-1:0]              slew_i,
  output logic [DATA_W-1:0]              vref_o,
  output logic [IDX_W-1:0]               idx_o,
  output logic                           step_o,
  output logic                           settled_o,
  output logic                           done_o
);

  // mode     | meaning
  // TRIANGLE | bounce between level 0 and the top level
  // SAWTOOTH | climb, then wrap from the top level to 0
  // SINGLE   | climb once and hold at the top level
  // MANUAL   | index follows sel_i every cycle, dwell counter parked at 0
  typedef enum logic [1:0] {
    MODE_TRI    = 2'd0,
    MODE_SAW    = 2'd1,
    MODE_SINGLE = 2'd2,
    MODE_MANUAL = 2'd3
  } mode_e;

  localparam logic [IDX_W-1:0] LAST     = IDX_W'(NUM_LEVELS - 1);
  localparam logic [IDX_W-1:0] PEN      = IDX_W'((NUM_LEVELS > 1) ? NUM_LEVELS - 2 : 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

  mode_e mode;
  assign mode = mode_e'(mode_i);

  logic [DATA_W-1:0] lvl [NUM_LEVELS];
  for (genvar k = 0; k < NUM_LEVELS; k++) begin : g_lvl
    assign lvl[k] = levels_i[k*DATA_W +: DATA_W];
  end

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              dir_down_q, dir_down_d;
  logic [DATA_W-1:0] target_q, target_d;
  logic [DATA_W-1:0] vref_q, vref_d;
  logic              step_q, done_q, done_d;
  logic              upd;
  logic [DATA_W:0]   diff;

  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    dir_down_d = dir_down_q;
    done_d     = done_q;
    upd        = 1'b0;
    if (mode == MODE_MANUAL) begin
      cnt_d  = '0;
      done_d = 1'b0;
      idx_d  = (sel_i > LAST) ? LAST : sel_i;
      upd    = (idx_d != idx_q);
    end else begin
      if (mode != MODE_SINGLE) done_d = 1'b0;
      if (en_i) begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          case (mode)
            MODE_TRI: begin
              upd = 1'b1;
              if (NUM_LEVELS == 1) begin
                idx_d = '0;
              end else if (!dir_down_q) begin
                if (idx_q == LAST) begin
                  dir_down_d = 1'b1;
                  idx_d      = PEN;
                end else begin
                  idx_d = idx_q + IDX_W'(1);
                end
              end else begin
                if (idx_q == '0) begin
                  dir_down_d = 1'b0;
                  idx_d      = IDX_W'(1);
                end else begin
                  idx_d = idx_q - IDX_W'(1);
                end
              end
            end
            MODE_SAW: begin
              upd   = 1'b1;
              idx_d = (idx_q == LAST) ? '0 : idx_q + IDX_W'(1);
            end
            MODE_SINGLE: begin
              if (idx_q == LAST) begin
                done_d = 1'b1;
              end else begin
                upd   = 1'b1;
                idx_d = idx_q + IDX_W'(1);
                if (idx_d == LAST) done_d = 1'b1;
              end
            end
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
    target_d = upd ? lvl[idx_d] : target_q;
  end

  // Slew limiter works on the registered target, so vref trails target by one edge
  always_comb begin
    diff   = '0;
    vref_d = vref_q;
    if (target_q >= vref_q) diff = {1'b0, target_q} - {1'b0, vref_q};
    else                    diff = {1'b0, vref_q} - {1'b0, target_q};
    if (slew_i == '0 || diff <= {1'b0, slew_i}) vref_d = target_q;
    else if (target_q > vref_q)                  vref_d = vref_q + slew_i;
    else                                         vref_d = vref_q - slew_i;
  end

  always_ff @(posedge clk_100m or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      dir_down_q <= 1'b0;
      target_q   <= '0;
      vref_q     <= '0;
      step_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      dir_down_q <= dir_down_d;
      target_q   <= target_d;
      vref_q     <= vref_d;
      step_q     <= upd;
      done_q     <= done_d;
    end
  end

  assign vref_o    = vref_q;
  assign idx_o     = idx_q;
  assign step_o    = step_q;
  assign done_o    = done_q;
  assign settled_o = (vref_q == target_q);

endmodule

// File: tb/tb_vref_profile_gen.sv
// Directed bench for vref_profile_gen: 4-level main instance, 3-level instance for sel clamping.
module tb_vref_profile_gen;

  localparam int DW = 16;

  logic clk_100m = 1'b0;
  logic rst_ni   = 1'b0;
  logic en_i     = 1'b1;
  logic [1:0] mode_i = 2'd0;
  logic [1:0] sel_i  = 2'd0;
  logic [1:0] sel3_i = 2'd0;
  logic [DW-1:0] slew_i = '0;
  logic [4*DW-1:0] levels_i = {16'h733A, 16'h4CCE, 16'h2653, 16'h0000};
  logic [3*DW-1:0] levels3_i = {16'h4CCE, 16'h2653, 16'h0000};

  logic [DW-1:0] vref_o, vref3_o;
  logic [1:0]    idx_o, idx3_o;
  logic          step_o, settled_o, done_o;
  logic          step3_o, settled3_o, done3_o;

  int tests_run = 0;
  int tests_failed = 0;

  logic [DW-1:0] lv [4] = '{16'h0000, 16'h2653, 16'h4CCE, 16'h733A};

  always #5 clk_100m = ~clk_100m;

  vref_profile_gen #(.DATA_W(DW), .NUM_LEVELS(4), .STEP_CYCLES(8)) dut (
    .clk_100m(clk_100m), .rst_ni(rst_ni), .en_i(en_i), .mode_i(mode_i),
    .sel_i(sel_i), .levels_i(levels_i), .slew_i(slew_i), .vref_o(vref_o),
    .idx_o(idx_o), .step_o(step_o), .settled_o(settled_o), .done_o(done_o)
  );

  vref_profile_gen #(.DATA_W(DW), .NUM_LEVELS(3), .STEP_CYCLES(8)) dut3 (
    .clk_100m(clk_100m), .rst_ni(rst_ni), .en_i(en_i), .mode_i(mode_i),
    .sel_i(sel3_i), .levels_i(levels3_i), .slew_i(slew_i), .vref_o(vref3_o),
    .idx_o(idx3_o), .step_o(step3_o), .settled_o(settled3_o), .done_o(done3_o)
  );

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk_100m);
    #1;
  endtask

  // Leaves the bench 1 time unit after the release edge; the next posedge is edge 1
  task automatic apply_reset();
    @(posedge clk_100m); #1;
    rst_ni = 1'b0;
    @(posedge clk_100m); #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk_100m); #1;
    rst_ni = 1'b0;
    #2;
    tests_run++;
    if (vref_o !== 16'h0000) begin tests_failed++; $display("FAIL reset_vref got %h exp 0000", vref_o); end
    tests_run++;
    if (idx_o !== 2'd0) begin tests_failed++; $display("FAIL reset_idx got %0d exp 0", idx_o); end
    tests_run++;
    if (step_o !== 1'b0) begin tests_failed++; $display("FAIL reset_step got %b exp 0", step_o); end
    tests_run++;
    if (settled_o !== 1'b1) begin tests_failed++; $display("FAIL reset_settled got %b exp 1", settled_o); end
    tests_run++;
    if (done_o !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b exp 0", done_o); end
  endtask

  task automatic test_triangle();
    int seq [7] = '{1, 2, 3, 2, 1, 0, 1};
    int ie, ip;
    mode_i = 2'd0; slew_i = '0; en_i = 1'b1;
    apply_reset();
    ip = 0;
    for (int k = 1; k <= 57; k++) begin
      wait_edges(1);
      ie = (k < 8) ? 0 : seq[k/8 - 1];
      tests_run++;
      if (idx_o !== 2'(ie)) begin tests_failed++; $display("FAIL tri_idx edge %0d got %0d exp %0d", k, idx_o, ie); end
      tests_run++;
      if (step_o !== (k >= 8 && k % 8 == 0)) begin tests_failed++; $display("FAIL tri_step edge %0d got %b", k, step_o); end
      tests_run++;
      if (vref_o !== lv[ip]) begin tests_failed++; $display("FAIL tri_vref edge %0d got %h exp %h", k, vref_o, lv[ip]); end
      ip = ie;
    end
  endtask

  task automatic test_sawtooth();
    int seq [5] = '{1, 2, 3, 0, 1};
    int ie, ip;
    mode_i = 2'd1; slew_i = '0; en_i = 1'b1;
    apply_reset();
    ip = 0;
    for (int k = 1; k <= 41; k++) begin
      wait_edges(1);
      ie = (k < 8) ? 0 : seq[k/8 - 1];
      tests_run++;
      if (idx_o !== 2'(ie)) begin tests_failed++; $display("FAIL saw_idx edge %0d got %0d exp %0d", k, idx_o, ie); end
      tests_run++;
      if (step_o !== (k >= 8 && k % 8 == 0)) begin tests_failed++; $display("FAIL saw_step edge %0d got %b", k, step_o); end
      tests_run++;
      if (vref_o !== lv[ip]) begin tests_failed++; $display("FAIL saw_vref edge %0d got %h exp %h", k, vref_o, lv[ip]); end
      ip = ie;
    end
  endtask

  task automatic test_single();
    int ie;
    mode_i = 2'd2; slew_i = '0; en_i = 1'b1;
    apply_reset();
    for (int k = 1; k <= 72; k++) begin
      wait_edges(1);
      ie = (k < 8) ? 0 : (k < 16) ? 1 : (k < 24) ? 2 : 3;
      tests_run++;
      if (idx_o !== 2'(ie)) begin tests_failed++; $display("FAIL single_idx edge %0d got %0d exp %0d", k, idx_o, ie); end
      tests_run++;
      if (done_o !== (k >= 24)) begin tests_failed++; $display("FAIL single_done edge %0d got %b", k, done_o); end
      tests_run++;
      if (step_o !== (k == 8 || k == 16 || k == 24)) begin tests_failed++; $display("FAIL single_step edge %0d got %b", k, step_o); end
    end
    mode_i = 2'd0;
    wait_edges(1);
    tests_run++;
    if (done_o !== 1'b0) begin tests_failed++; $display("FAIL single_done_clear got %b exp 0", done_o); end
    wait_edges(6);
    tests_run++;
    if (idx_o !== 2'd3) begin tests_failed++; $display("FAIL single_pre_tri_idx got %0d exp 3", idx_o); end
    wait_edges(1);
    tests_run++;
    if (idx_o !== 2'd2) begin tests_failed++; $display("FAIL single_to_tri_idx got %0d exp 2", idx_o); end
    tests_run++;
    if (step_o !== 1'b1) begin tests_failed++; $display("FAIL single_to_tri_step got %b exp 1", step_o); end
  endtask

  task automatic test_slew();
    logic [DW-1:0] vexp [36];
    logic          sexp [36];
    for (int k = 0; k < 36; k++) begin vexp[k] = 16'h0000; sexp[k] = 1'b1; end
    vexp[9]  = 16'h1000; vexp[10] = 16'h2000;
    for (int k = 11; k <= 16; k++) vexp[k] = 16'h2653;
    vexp[17] = 16'h3653; vexp[18] = 16'h4653;
    for (int k = 19; k <= 24; k++) vexp[k] = 16'h4CCE;
    vexp[25] = 16'h5CCE; vexp[26] = 16'h6CCE;
    for (int k = 27; k <= 32; k++) vexp[k] = 16'h733A;
    vexp[33] = 16'h633A; vexp[34] = 16'h533A; vexp[35] = 16'h4CCE;
    sexp[8]  = 1'b0; sexp[9]  = 1'b0; sexp[10] = 1'b0;
    sexp[16] = 1'b0; sexp[17] = 1'b0; sexp[18] = 1'b0;
    sexp[24] = 1'b0; sexp[25] = 1'b0; sexp[26] = 1'b0;
    sexp[32] = 1'b0; sexp[33] = 1'b0; sexp[34] = 1'b0;
    mode_i = 2'd0; slew_i = 16'h1000; en_i = 1'b1;
    apply_reset();
    for (int k = 1; k <= 35; k++) begin
      wait_edges(1);
      tests_run++;
      if (vref_o !== vexp[k]) begin tests_failed++; $display("FAIL slew_vref edge %0d got %h exp %h", k, vref_o, vexp[k]); end
      tests_run++;
      if (settled_o !== sexp[k]) begin tests_failed++; $display("FAIL slew_settled edge %0d got %b exp %b", k, settled_o, sexp[k]); end
    end
    slew_i = '0;
  endtask

  task automatic test_manual();
    mode_i = 2'd3; sel_i = 2'd0; sel3_i = 2'd3; slew_i = '0; en_i = 1'b1;
    apply_reset();
    for (int k = 1; k <= 15; k++) begin
      wait_edges(1);
      if (k == 3) sel_i = 2'd2;
      tests_run++;
      if (idx_o !== ((k >= 4) ? 2'd2 : 2'd0)) begin tests_failed++; $display("FAIL man_idx edge %0d got %0d", k, idx_o); end
      tests_run++;
      if (step_o !== (k == 4)) begin tests_failed++; $display("FAIL man_step edge %0d got %b", k, step_o); end
      tests_run++;
      if (vref_o !== ((k >= 5) ? 16'h4CCE : 16'h0000)) begin tests_failed++; $display("FAIL man_vref edge %0d got %h", k, vref_o); end
      tests_run++;
      if (idx3_o !== 2'd2) begin tests_failed++; $display("FAIL man_clamp_idx edge %0d got %0d exp 2", k, idx3_o); end
      tests_run++;
      if (step3_o !== (k == 1)) begin tests_failed++; $display("FAIL man_clamp_step edge %0d got %b", k, step3_o); end
      tests_run++;
      if (vref3_o !== ((k >= 2) ? 16'h4CCE : 16'h0000)) begin tests_failed++; $display("FAIL man_clamp_vref edge %0d got %h", k, vref3_o); end
    end
    mode_i = 2'd0;
    wait_edges(7);
    tests_run++;
    if (idx_o !== 2'd2) begin tests_failed++; $display("FAIL man_exit_hold got %0d exp 2", idx_o); end
    wait_edges(1);
    tests_run++;
    if (idx_o !== 2'd3) begin tests_failed++; $display("FAIL man_exit_tick got %0d exp 3", idx_o); end
    tests_run++;
    if (step_o !== 1'b1) begin tests_failed++; $display("FAIL man_exit_step got %b exp 1", step_o); end
  endtask

  task automatic test_enable();
    mode_i = 2'd0; slew_i = '0; en_i = 1'b1;
    apply_reset();
    wait_edges(3);
    en_i = 1'b0;
    wait_edges(20);
    en_i = 1'b1;
    wait_edges(4);
    tests_run++;
    if (idx_o !== 2'd0) begin tests_failed++; $display("FAIL en_hold_idx got %0d exp 0", idx_o); end
    wait_edges(1);
    tests_run++;
    if (idx_o !== 2'd1) begin tests_failed++; $display("FAIL en_delay_idx got %0d exp 1", idx_o); end
    tests_run++;
    if (step_o !== 1'b1) begin tests_failed++; $display("FAIL en_delay_step got %b exp 1", step_o); end
    wait_edges(7);
    en_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_edges(1);
      tests_run++;
      if (idx_o !== 2'd1 || step_o !== 1'b0) begin tests_failed++; $display("FAIL en_tick_suppress cyc %0d idx %0d step %b exp idx 1 step 0", k, idx_o, step_o); end
    end
    en_i = 1'b1;
    wait_edges(1);
    tests_run++;
    if (idx_o !== 2'd2) begin tests_failed++; $display("FAIL en_tick_resume got %0d exp 2", idx_o); end
  endtask

  task automatic test_async_reset();
    mode_i = 2'd2; slew_i = 16'h1000; en_i = 1'b1;
    apply_reset();
    wait_edges(25);
    tests_run++;
    if (vref_o !== 16'h5CCE || done_o !== 1'b1) begin tests_failed++; $display("FAIL arst_pre vref %h done %b exp 5cce 1", vref_o, done_o); end
    #2;
    rst_ni = 1'b0;
    #1;
    tests_run++;
    if (vref_o !== 16'h0000) begin tests_failed++; $display("FAIL arst_vref got %h exp 0000", vref_o); end
    tests_run++;
    if (idx_o !== 2'd0) begin tests_failed++; $display("FAIL arst_idx got %0d exp 0", idx_o); end
    tests_run++;
    if (done_o !== 1'b0) begin tests_failed++; $display("FAIL arst_done got %b exp 0", done_o); end
    @(posedge clk_100m); #1;
    rst_ni = 1'b1;
    wait_edges(8);
    tests_run++;
    if (idx_o !== 2'd1 || step_o !== 1'b1) begin tests_failed++; $display("FAIL arst_restart idx %0d step %b exp 1 1", idx_o, step_o); end
    slew_i = '0;
  endtask

  initial begin
    test_reset();
    test_triangle();
    test_sawtooth();
    test_single();
    test_slew();
    test_manual();
    test_enable();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vref_profile_gen.md
# vref_profile_gen

Parametrised reference-profile generator for the 3LFCC converter control loop: produces the output-voltage reference `vref_o` that feeds the `fcc_fixpt` controller's `Voutref` input. It generalises the fixed 4-level soft-start sequencer to N programmable levels, four sequencing modes and optional slew-rate limiting. It adds step, settled and done status for supervision and test.

## Interface
- `DATA_W`, 16, width of levels and reference (fixed-point, same format as ADC measurements)
- `NUM_LEVELS`, 4, number of reference levels (≥1)
- `STEP_CYCLES`, 1000000, enabled clock cycles per level dwell (≥2)
- `IDX_W`, `$clog2(NUM_LEVELS)` (min 1), index width
- `CNT_W`, `$clog2(STEP_CYCLES)`, dwell counter width

- `clk_100m`  in  1  system clock
- `rst_ni`  in  1  asynchronous, active-low reset
- `en_i`  in  1  sequencing enable; low freezes dwell counter and index
- `mode_i`  in  2  0=TRIANGLE, 1=SAWTOOTH, 2=SINGLE, 3=MANUAL
- `sel_i`  in  IDX_W  level select in MANUAL
- `levels_i`  in  NUM_LEVELS*DATA_W  level table, level k at bits [k*DATA_W +: DATA_W]
- `slew_i`  in  DATA_W  max vref change per cycle; 0 = immediate jump
- `vref_o`  out  DATA_W  reference output
- `idx_o`  out  IDX_W  current level index
- `step_o`  out  1  one-cycle pulse when idx_o/target updates
- `settled_o`  out  1  vref_o equals target
- `done_o`  out  1  SINGLE mode reached top level

## Operation
- Reset values: vref_o=0, target=0, idx_o=0, direction=up, dwell counter=0, step_o=0, done_o=0, settled_o=1.
- Dwell counter: increments each cycle with en_i=1 (non-MANUAL); at STEP_CYCLES-1 wraps to 0 and raises an internal tick. en_i=0 holds counter value.
- On tick, next index by mode:
  - TRIANGLE: up until NUM_LEVELS-1, then direction=down and next=NUM_LEVELS-2; down until 0, then direction=up and next=1.
  - SAWTOOTH: idx+1, NUM_LEVELS-1 wraps to 0. Direction is not changed.
  - SINGLE: idx+1 until NUM_LEVELS-1, then hold. done_o=1 from the cycle idx reaches NUM_LEVELS-1, and no further step_o pulses. done_o clears when mode_i≠SINGLE. Entering SINGLE continues upward from the current idx.
  - NUM_LEVELS=1: idx stays 0 in all modes. step_o still pulses on tick, except in SINGLE, where done_o=1 after the first tick.
- MANUAL: dwell counter held at 0, en_i ignored. Each cycle, idx <= min(sel_i, NUM_LEVELS-1). step_o pulses only when the index changes. done_o=0.
- Target register: loaded with levels_i[idx_next] in the same edge as idx_o. levels_i is sampled only on these updates.
- Slew (per cycle, unsigned, DATA_W+1-bit difference, no overshoot):
  - if slew_i=0 or |target−vref|≤slew_i: vref<=target
  - else vref moves slew_i toward target
  - Slew continues while en_i=0.
- settled_o = (vref_o == target), from registers.
- Mode change takes effect at the next tick (MANUAL: next edge). Direction is preserved across modes. Leaving MANUAL resumes counting from 0.

## Timing
- First tick after STEP_CYCLES enabled cycles following reset release.
- idx_o, target and step_o update on the edge after the tick cycle.
- vref_o begins moving one cycle after target updates. With slew_i=0, latency from tick to vref_o is 2 cycles.
- Slewed settle: ceil(|Δ|/slew_i) cycles after start.
- MANUAL: sel_i change → idx_o next edge → vref_o one edge later (slew_i=0).
- Async reset mid-ramp: all outputs return to reset values immediately. Sequencing restarts from idx 0, direction up.
- en_i deassert on the tick cycle: that tick is suppressed and the counter holds at STEP_CYCLES-1.

## Test plan
Setup: STEP_CYCLES=8, levels 0x0000/0x2653/0x4CCE/0x733A.

- **TRIANGLE, slew_i=0, en_i=1:** idx_o sequence 1,2,3,2,1,0,1 every 8 cycles; vref_o follows the matching level 2 cycles after each tick; step_o exactly one cycle per tick.
- **SAWTOOTH:** idx_o 1,2,3,0,1; vref_o 0x733A→0x0000 on the wrap.
- **SINGLE:** idx_o stops at 3; done_o=1 from that edge; no step_o for ≥40 cycles. Switching to TRIANGLE clears done_o and yields idx 2 at the next tick.
- **Slew, slew_i=0x1000, 0→0x2653:** vref_o 0x1000, 0x2000, 0x2653; settled_o low for 2 cycles, high on the third; no overshoot.
- **MANUAL:** sel_i=2 → idx_o=2 next edge, vref_o=0x4CCE one edge later, one step_o. sel_i held → no further step_o. sel_i beyond range (NUM_LEVELS=3 build) → idx_o=2.
- **en_i and reset:** en_i low for 20 cycles mid-dwell delays the next tick by exactly 20 cycles. rst_ni pulsed mid-slew → vref_o=0, idx_o=0, done_o=0 asynchronously.
